// File: rtl/sim_mem_ctl_pkg.sv
// Shared types for sim_mem_ctl: request command encoding and controller states.
package sim_mem_ctl_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_RPW   = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RPW_WRITE = 3'd4
    } state_t;

    // Commands that perform a memory access when the RPW path is compiled in.
    function automatic logic cmd_is_access(input cmd_t c, input logic rpw_en);
        return (c == CMD_READ) || (c == CMD_WRITE) || (rpw_en && (c == CMD_RPW));
    endfunction

endpackage

// File: rtl/sim_mem_ctl.sv
// Request-stream front end for sim_mem: READ, WRITE and read-pause-write commands.
// Define SIM_MEM_CTL_RPW_EN to compile in the RPW / PAUSE / RPW_WRITE path.
module sim_mem_ctl
    import sim_mem_ctl_pkg::*;
#(
    parameter int SIZE   = 1024,
    parameter int WIDTH  = 36,
    parameter int NBYTES = 3,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [AW-1:0]     req_addr,
    input  logic [WIDTH-1:0]  req_data,
    input  logic [NBYTES-1:0] req_lanes,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [AW-1:0]     mem_addr,
    output logic [WIDTH-1:0]  mem_din,
    output logic [NBYTES-1:0] mem_wea,
    input  logic [WIDTH-1:0]  mem_dout,
    output logic              paused
);

    if ((WIDTH % NBYTES) != 0) begin : g_bad_lanes
        $error("sim_mem_ctl: WIDTH must be a multiple of NBYTES");
    end

`ifdef SIM_MEM_CTL_RPW_EN
    localparam logic RPW_EN = 1'b1;
`else
    localparam logic RPW_EN = 1'b0;
`endif

    state_t            r_state;
    logic [AW-1:0]     r_mem_addr;
    logic [WIDTH-1:0]  r_mem_din;
    logic [NBYTES-1:0] r_mem_wea;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_err;
    logic              r_err_pend;

    cmd_t w_cmd;
    logic w_acc;
    logic w_addr_ok;
    logic w_cmd_ok;

    assign w_cmd     = cmd_t'(req_cmd);
    assign w_acc     = req_valid && req_ready;
    assign w_addr_ok = (32'(req_addr) < SIZE);
    assign w_cmd_ok  = cmd_is_access(w_cmd, RPW_EN);

`ifdef SIM_MEM_CTL_RPW_EN
    logic r_rpw;
    logic r_paused;
    assign req_ready = (r_state == ST_IDLE) || (r_state == ST_PAUSE);
    assign paused    = r_paused;
`else
    assign req_ready = (r_state == ST_IDLE);
    assign paused    = 1'b0;
`endif

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wea   = r_mem_wea;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    // Every accepted request responds exactly one edge later, so the rejected-request
    // pulse (r_err_pend) can never collide with a read/write completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_mem_wea   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_err_pend  <= 1'b0;
`ifdef SIM_MEM_CTL_RPW_EN
            r_rpw       <= 1'b0;
            r_paused    <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= r_err_pend;
            r_rsp_err   <= r_err_pend;
            r_rsp_data  <= '0;
            r_err_pend  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (!w_cmd_ok || !w_addr_ok) begin
                            r_err_pend <= 1'b1;
                        end else begin
                            r_mem_addr <= req_addr;
                            if (w_cmd == CMD_WRITE) begin
                                r_mem_din <= req_data;
                                r_mem_wea <= req_lanes;
                                r_state   <= ST_WRITE;
                            end else begin
`ifdef SIM_MEM_CTL_RPW_EN
                                r_rpw   <= (w_cmd == CMD_RPW);
`endif
                                r_state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= mem_dout;
`ifdef SIM_MEM_CTL_RPW_EN
                    r_rpw    <= 1'b0;
                    r_paused <= r_rpw;
                    r_state  <= r_rpw ? ST_PAUSE : ST_IDLE;
`else
                    r_state  <= ST_IDLE;
`endif
                end
                ST_WRITE: begin
                    r_mem_din   <= '0;
                    r_mem_wea   <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
`ifdef SIM_MEM_CTL_RPW_EN
                ST_PAUSE: begin
                    // The held read address is the write target; req_addr is ignored.
                    if (w_acc) begin
                        if (w_cmd == CMD_WRITE) begin
                            r_mem_din <= req_data;
                            r_mem_wea <= req_lanes;
                            r_paused  <= 1'b0;
                            r_state   <= ST_RPW_WRITE;
                        end else begin
                            r_err_pend <= 1'b1;
                        end
                    end
                end
                ST_RPW_WRITE: begin
                    r_mem_din   <= '0;
                    r_mem_wea   <= '0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
